reset_request_gen: RTL and testbench
====================================

// Module: reset_request_gen
// PURPOSE
//  Generates qualified reset requests (push-button, software, optional watchdog) and drives the
//  request input of the delayed-reset release stage. That stage stretches reset release; this block
//  qualifies reset assertion: debounces the button, issues a fixed-width request pulse, records cause.
//  Sits in the always-on clocking/reset domain. Reset must be power-on only, never derived from opResetReq.
// PARAMETERS
//  Clk_Frequency      50_000_000  ipClk frequency in Hz
//  Debounce_ms        10          button must be stable-pressed this long before a request
//  Pulse_ms           1           width of opResetReq pulse
//  Button_Active_Low  1           1: ipButton low = pressed; 0: high = pressed
//  Watchdog_ms        1000        watchdog timeout (used only with RESET_REQ_WATCHDOG_EN)
// PORTS
//  ipClk       in   1  clock
//  Reset       in   1  reset: synchronous, active-high, sampled on ipClk
//  ipButton    in   1  asynchronous push-button level
//  ipSoftReq   in   1  software request, single-cycle pulse, synchronous to ipClk
//  ipKick      in   1  watchdog kick, single-cycle pulse (ignored without RESET_REQ_WATCHDOG_EN)
//  opResetReq  out  1  reset request pulse, registered, exactly Pulse_cycles wide
//  opBusy      out  1  high in any state other than IDLE
//  opCause     out  2  cause of last request: 0 NONE, 1 BUTTON, 2 SOFT, 3 WDOG
// BEHAVIOUR
//  - Cycle counts: X_cycles = (Clk_Frequency/1000)*X_ms; counter width $clog2(max+1).
//  - ipButton -> 2-FF synchroniser -> normalised "pressed" (polarity per Button_Active_Low).
//  - Reset: state IDLE, counters 0, opResetReq 0, opBusy 0, opCause 0; synchroniser flops forced to released.
//  - IDLE: priority WDOG expiry > ipSoftReq > pressed. Expiry/soft -> PULSE with opCause updated
//    same edge; pressed -> DEBOUNCE, debounce count 0.
//  - DEBOUNCE: released -> IDLE, no request. Count reaches Debounce_cycles-1 while pressed -> PULSE, cause BUTTON.
//  - PULSE: opResetReq 1 for exactly Pulse_cycles cycles, then HOLDOFF.
//  - HOLDOFF: wait until pressed = 0 (1 cycle minimum) -> IDLE. Held button never retriggers.
//  - Latency: ipSoftReq high at edge n -> opResetReq high after edge n+1 (one register).
//  - ipSoftReq outside IDLE is dropped, not queued. opCause holds until next request.
//  - Reset mid-PULSE: opResetReq falls at next edge; all state cleared.
// CONFIGURATION
//  RESET_REQ_WATCHDOG_EN defined: watchdog counter runs in IDLE/DEBOUNCE, cleared by ipKick, Reset and
//    PULSE entry; count reaching Watchdog_cycles-1 = expiry. Kick coincident with expiry: kick wins, no request.
//  Not defined: no watchdog counter, ipKick ignored, opCause never 3.
// STRUCTURE
//  Package reset_req_pkg: cause enum (NONE/BUTTON/SOFT/WDOG), state enum (IDLE/DEBOUNCE/PULSE/HOLDOFF),
//    ms_to_cycles(freq, ms) constant function.
//  Sub-module sync_2ff: two-flop synchroniser, parameterised reset value.
// TESTING (Clk_Frequency=1_000_000, Debounce_ms=2, Pulse_ms=1, Watchdog_ms=5, Active_Low=1)
//  - Reset held 5 cycles -> opResetReq 0, opBusy 0, opCause 0 throughout and after release.
//  - ipSoftReq pulse at cycle 10 -> opResetReq high cycles 11..1010 (1000 cycles), opCause 2.
//  - ipButton low 1500 cycles then high -> no opResetReq; opBusy falls by cycle 1503.
//  - ipButton low 10000 cycles -> opResetReq pulse 1000 wide, opCause 1; no second pulse while held.
//  - ipSoftReq during PULSE -> ignored; exactly one pulse observed.
//  - WATCHDOG_EN, no kicks -> pulse 5000 cycles after Reset, opCause 3; kick at cycle 4999 -> none.

Source files
------------

// File: rtl/reset_request_gen_pkg.sv
// Package reset_req_pkg
//  Shared types and helpers for the reset request generator.
//  - cause_e : cause of the last reset request (NONE/BUTTON/SOFT/WDOG)
//  - state_e : request FSM states (IDLE/DEBOUNCE/PULSE/HOLDOFF)
//  - ms_to_cycles : converts a duration in ms into ipClk cycles
package reset_req_pkg;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'd0,
    CAUSE_BUTTON = 2'd1,
    CAUSE_SOFT   = 2'd2,
    CAUSE_WDOG   = 2'd3
  } cause_e;

  typedef enum logic [1:0] {
    STATE_IDLE     = 2'd0,
    STATE_DEBOUNCE = 2'd1,
    STATE_PULSE    = 2'd2,
    STATE_HOLDOFF  = 2'd3
  } state_e;

  // Frequency is divided first so the intermediate product stays within 32 bits.
  function automatic int unsigned ms_to_cycles(input int unsigned freq, input int unsigned ms);
    return (freq / 1000) * ms;
  endfunction

endpackage

// File: rtl/reset_request_gen_sync_2ff.sv
// Module sync_2ff
//  Two-flop synchroniser for a single asynchronous level.
//  Ports:
//   ipClk  in  1  destination clock
//   Reset  in  1  synchronous, active-high; forces both flops to ResetValue
//   ipD    in  1  asynchronous input level
//   opQ    out 1  synchronised level (two ipClk cycles of latency)
module sync_2ff #(
  parameter logic ResetValue = 1'b0
) (
  input  logic ipClk,
  input  logic Reset,
  input  logic ipD,
  output logic opQ
);

  logic metaStage;

  always_ff @(posedge ipClk) begin
    if (Reset) begin
      metaStage <= ResetValue;
      opQ       <= ResetValue;
    end else begin
      metaStage <= ipD;
      opQ       <= metaStage;
    end
  end

endmodule

// File: rtl/reset_request_gen.sv
// Module reset_request_gen
//  Qualifies reset requests (push-button, software, optional watchdog) and
//  issues a fixed-width request pulse to the delayed-reset release stage.
//  Reset must come from power-on only, never from opResetReq.
//  Optional feature macro: RESET_REQ_WATCHDOG_EN (adds the watchdog timer).
//  Ports:
//   ipClk       in  1  clock
//   Reset       in  1  synchronous, active-high reset
//   ipButton    in  1  asynchronous push-button level
//   ipSoftReq   in  1  software request, single-cycle pulse
//   ipKick      in  1  watchdog kick, single-cycle pulse (ignored without watchdog)
//   opResetReq  out 1  registered request pulse, Pulse_ms worth of cycles wide
//   opBusy      out 1  high whenever the FSM is not in IDLE
//   opCause     out 2  cause of the last request (0 NONE,1 BUTTON,2 SOFT,3 WDOG)
module reset_request_gen
  import reset_req_pkg::*;
#(
  parameter int unsigned Clk_Frequency     = 50_000_000,
  parameter int unsigned Debounce_ms       = 10,
  parameter int unsigned Pulse_ms          = 1,
  parameter bit          Button_Active_Low = 1'b1,
  parameter int unsigned Watchdog_ms       = 1000
) (
  input  logic       ipClk,
  input  logic       Reset,
  input  logic       ipButton,
  input  logic       ipSoftReq,
  input  logic       ipKick,
  output logic       opResetReq,
  output logic       opBusy,
  output logic [1:0] opCause
);

  localparam int unsigned DebounceCycles = ms_to_cycles(Clk_Frequency, Debounce_ms);
  localparam int unsigned PulseCycles    = ms_to_cycles(Clk_Frequency, Pulse_ms);
  // Debounce and pulse timing never overlap, so one counter serves both.
  localparam int unsigned PhaseMax   = (DebounceCycles > PulseCycles) ? DebounceCycles : PulseCycles;
  localparam int          PhaseWidth = $clog2(PhaseMax + 1);

  localparam logic [1:0] Idle     = STATE_IDLE;
  localparam logic [1:0] Debounce = STATE_DEBOUNCE;
  localparam logic [1:0] Pulse    = STATE_PULSE;
  localparam logic [1:0] Holdoff  = STATE_HOLDOFF;

  logic [1:0]            stateReg;
  logic [PhaseWidth-1:0] phaseCount;
  logic                  syncButton;
  logic                  pressed;
  logic                  wdExpire;
  logic                  startPulse;
  cause_e                startCause;

  // Flops come out of reset at the released level so no press is seen on release.
  sync_2ff #(
    .ResetValue(Button_Active_Low)
  ) buttonSync (
    .ipClk(ipClk),
    .Reset(Reset),
    .ipD  (ipButton),
    .opQ  (syncButton)
  );

  assign pressed = Button_Active_Low ? ~syncButton : syncButton;
  assign opBusy  = (stateReg != Idle);

`ifdef RESET_REQ_WATCHDOG_EN
  localparam int unsigned WatchdogCycles = ms_to_cycles(Clk_Frequency, Watchdog_ms);
  localparam int          WdWidth        = $clog2(WatchdogCycles + 1);

  logic [WdWidth-1:0] wdCount;
  logic               wdRunning;

  assign wdRunning = (stateReg == Idle) || (stateReg == Debounce);
  // A kick on the expiry cycle rescues the system.
  assign wdExpire  = wdRunning && !ipKick && (wdCount == WdWidth'(WatchdogCycles - 1));

  always_ff @(posedge ipClk) begin
    if (Reset || ipKick || startPulse) begin
      wdCount <= '0;
    end else if (wdRunning) begin
      wdCount <= wdCount + WdWidth'(1);
    end
  end
`else
  logic unusedKick;
  assign unusedKick = ipKick;
  assign wdExpire   = 1'b0;
`endif

  // Request arbitration: watchdog expiry beats software, software beats a
  // completed debounce. Expiry is also honoured during DEBOUNCE so a bouncing
  // button cannot postpone it.
  always_comb begin
    startPulse = 1'b0;
    startCause = CAUSE_NONE;
    case (stateReg)
      Idle: begin
        if (wdExpire) begin
          startPulse = 1'b1;
          startCause = CAUSE_WDOG;
        end else if (ipSoftReq) begin
          startPulse = 1'b1;
          startCause = CAUSE_SOFT;
        end
      end
      Debounce: begin
        if (wdExpire) begin
          startPulse = 1'b1;
          startCause = CAUSE_WDOG;
        end else if (pressed && (phaseCount == PhaseWidth'(DebounceCycles - 1))) begin
          startPulse = 1'b1;
          startCause = CAUSE_BUTTON;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge ipClk) begin
    if (Reset) begin
      stateReg   <= Idle;
      phaseCount <= '0;
      opResetReq <= 1'b0;
      opCause    <= CAUSE_NONE;
    end else if (startPulse) begin
      stateReg   <= Pulse;
      phaseCount <= '0;
      opResetReq <= 1'b1;
      opCause    <= startCause;
    end else begin
      case (stateReg)
        Idle: begin
          if (pressed) begin
            stateReg   <= Debounce;
            phaseCount <= '0;
          end
        end
        Debounce: begin
          if (!pressed) begin
            stateReg <= Idle;
          end else begin
            phaseCount <= phaseCount + PhaseWidth'(1);
          end
        end
        Pulse: begin
          if (phaseCount == PhaseWidth'(PulseCycles - 1)) begin
            stateReg   <= Holdoff;
            opResetReq <= 1'b0;
          end else begin
            phaseCount <= phaseCount + PhaseWidth'(1);
          end
        end
        Holdoff: begin
          // A held button must be released before another press can count.
          if (!pressed) begin
            stateReg <= Idle;
          end
        end
        default: stateReg <= Idle;
      endcase
    end
  end

endmodule

// File: tb/tb_reset_request_gen.sv
// Testbench tb_reset_request_gen
//  Directed stimulus for reset_request_gen at 1 MHz (1000 cycles per ms).
//  Expected pulses (start cycle, width, cause) are queued when stimulus is
//  issued; a monitor measures every opResetReq pulse and compares on its fall.
//  Watchdog scenarios run only when RESET_REQ_WATCHDOG_EN is defined.
module tb_reset_request_gen;

  logic       ipClk = 1'b0;
  logic       Reset;
  logic       ipButton;
  logic       ipSoftReq;
  logic       ipKick;
  logic       opResetReq;
  logic       opBusy;
  logic [1:0] opCause;

  typedef struct {
    int start;
    int width;
    int cause;
  } pulse_t;

  pulse_t expQ[$];
  int     cycNum   = 0;
  int     checks   = 0;
  int     errors   = 0;
  bit     autoKick = 1'b0;
  int     kickAt   = -1;

  reset_request_gen #(
    .Clk_Frequency    (1_000_000),
    .Debounce_ms      (2),
    .Pulse_ms         (1),
    .Button_Active_Low(1'b1),
    .Watchdog_ms      (5)
  ) dut (
    .ipClk     (ipClk),
    .Reset     (Reset),
    .ipButton  (ipButton),
    .ipSoftReq (ipSoftReq),
    .ipKick    (ipKick),
    .opResetReq(opResetReq),
    .opBusy    (opBusy),
    .opCause   (opCause)
  );

  always #5 ipClk = ~ipClk;

  always @(posedge ipClk) cycNum <= cycNum + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycNum);
    end
  endtask

  task automatic pushExp(input int start, input int width, input int cause);
    pulse_t p;
    p.start = start;
    p.width = width;
    p.cause = cause;
    expQ.push_back(p);
  endtask

  task automatic waitCyc(input int n);
    repeat (n) @(negedge ipClk);
  endtask

  // Sole driver of ipKick: periodic kicks plus one directed kick cycle.
  initial begin
    ipKick = 1'b0;
    forever begin
      @(negedge ipClk);
      ipKick = (autoKick && ((cycNum % 2000) == 0)) || (cycNum == kickAt);
    end
  end

  // Pulse monitor / scoreboard.
  bit       prevReq = 1'b0;
  int       curStart;
  int       curWidth;
  int       curCause;
  pulse_t   e;
  always @(negedge ipClk) begin
    if (opResetReq === 1'b1) begin
      if (!prevReq) begin
        curStart = cycNum;
        curCause = int'(opCause);
        curWidth = 1;
      end else begin
        curWidth++;
      end
    end else if (prevReq) begin
      $display("pulse: start=%0d width=%0d cause=%0d", curStart, curWidth, curCause);
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got pulse at %0d expected none", curStart);
      end else begin
        e = expQ.pop_front();
        check("pulse_start", curStart, e.start);
        check("pulse_width", curWidth, e.width);
        check("pulse_cause", curCause, e.cause);
      end
    end
    prevReq = (opResetReq === 1'b1);
  end

  initial begin
    int d;
    int r;
    Reset     = 1'b1;
    ipButton  = 1'b1;
    ipSoftReq = 1'b0;

    // Reset held 5 cycles: everything quiet.
    for (int i = 0; i < 5; i++) begin
      @(negedge ipClk);
      check("rst_req", opResetReq, 0);
      check("rst_busy", opBusy, 0);
      check("rst_cause", opCause, 0);
    end
    Reset = 1'b0;
    r = cycNum;
    @(negedge ipClk);
    check("rel_req", opResetReq, 0);
    check("rel_busy", opBusy, 0);
    check("rel_cause", opCause, 0);

`ifdef RESET_REQ_WATCHDOG_EN
    // No kicks: expiry 5000 cycles after reset release.
    pushExp(r + 5000, 1000, 3);
    waitCyc(6100);
    check("wd_cause", opCause, 3);
    check("wd_busy", opBusy, 0);
    // Kick coincident with expiry: no request.
    Reset = 1'b1;
    waitCyc(2);
    Reset = 1'b0;
    kickAt = cycNum + 4999;
    waitCyc(5500);
    check("wdkick_cause", opCause, 0);
    check("wdkick_busy", opBusy, 0);
`endif
    autoKick = 1'b1;
    waitCyc(10);

    // Software request: one-register latency, 1000-cycle pulse.
    d = cycNum;
    ipSoftReq = 1'b1;
    pushExp(d + 1, 1000, 2);
    waitCyc(1);
    ipSoftReq = 1'b0;
    check("soft_busy", opBusy, 1);
    waitCyc(1100);
    check("soft_cause", opCause, 2);
    check("soft_idle", opBusy, 0);

    // Software request during PULSE is dropped.
    d = cycNum;
    ipSoftReq = 1'b1;
    pushExp(d + 1, 1000, 2);
    waitCyc(1);
    ipSoftReq = 1'b0;
    waitCyc(200);
    ipSoftReq = 1'b1;
    waitCyc(1);
    ipSoftReq = 1'b0;
    check("drop_busy", opBusy, 1);
    waitCyc(1000);
    check("drop_idle", opBusy, 0);

    // Short press (1500 < 2000 cycles): no request.
    ipButton = 1'b0;
    waitCyc(1000);
    check("short_busy", opBusy, 1);
    waitCyc(500);
    ipButton = 1'b1;
    waitCyc(3);
    check("short_idle", opBusy, 0);
    check("short_cause", opCause, 2);

    // Long press: 2 sync cycles + IDLE->DEBOUNCE edge + 2000 debounce cycles.
    d = cycNum;
    ipButton = 1'b0;
    pushExp(d + 2003, 1000, 1);
    waitCyc(10000);
    check("hold_busy", opBusy, 1);
    check("hold_req", opResetReq, 0);
    ipButton = 1'b1;
    waitCyc(4);
    check("hold_idle", opBusy, 0);
    check("hold_cause", opCause, 1);

    // Reset in the middle of a pulse truncates it and clears the cause.
    waitCyc(5);
    d = cycNum;
    ipSoftReq = 1'b1;
    pushExp(d + 1, 300, 2);
    waitCyc(1);
    ipSoftReq = 1'b0;
    waitCyc(299);
    Reset = 1'b1;
    waitCyc(1);
    check("midrst_req", opResetReq, 0);
    check("midrst_cause", opCause, 0);
    check("midrst_busy", opBusy, 0);
    Reset = 1'b0;
    waitCyc(10);

    check("pending_pulses", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
